// File: rtl/instr_encoder_loader.sv
// Encodes symbolic MIPS instruction descriptors into 32-bit words and
// streams them into instruction memory at sequential word addresses.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              err_illegal,
  output logic              overflow,
  output logic              done
);

  localparam logic [ADDR_W:0] BASE_P = BASE_ADDR[ADDR_W:0];

  localparam logic [2:0] K_R    = 3'd0;
  localparam logic [2:0] K_ADDI = 3'd1;
  localparam logic [2:0] K_LW   = 3'd2;
  localparam logic [2:0] K_SW   = 3'd3;
  localparam logic [2:0] K_ANDI = 3'd4;
  localparam logic [2:0] K_BEQ  = 3'd5;
  localparam logic [2:0] K_JAL  = 3'd6;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_JAL  = 6'h03;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [5:0] F_SLL = 6'h00;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FINISH
  } state_t;

  state_t            state;
  logic [ADDR_W:0]   ptr;
  logic              full;
  logic              funct_ok;
  logic              enc_ok;
  logic [31:0]       enc_word;

  // ptr carries one extra bit so a full memory never wraps back to 0
  assign full     = ptr[ADDR_W];
  assign in_ready = (state == S_LOAD) && !full;

  assign funct_ok = (in_funct == F_ADD) || (in_funct == F_AND) ||
                    (in_funct == F_NOR) || (in_funct == F_JR)  ||
                    (in_funct == F_SLT) || (in_funct == F_SLL);

  // Encode the presented descriptor and flag it as legal or not
  always_comb begin
    enc_ok   = 1'b1;
    enc_word = '0;
    unique case (1'b1)
      (in_kind == K_R): begin
        enc_ok   = funct_ok;
        enc_word = {OP_R, in_rs, in_rt, in_rd,
                    in_shamt, in_funct};
      end
      (in_kind == K_ADDI):
        enc_word = {OP_ADDI, in_rs, in_rt, in_imm};
      (in_kind == K_LW):
        enc_word = {OP_LW, in_rs, in_rt, in_imm};
      (in_kind == K_SW):
        enc_word = {OP_SW, in_rs, in_rt, in_imm};
      (in_kind == K_ANDI):
        enc_word = {OP_ANDI, in_rs, in_rt, in_imm};
      (in_kind == K_BEQ):
        enc_word = {OP_BEQ, in_rs, in_rt, in_imm};
      (in_kind == K_JAL):
        enc_word = {OP_JAL, in_target};
      default:
        enc_ok = 1'b0;
    endcase
  end

  // Session FSM with registered write port, counters and flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ptr         <= BASE_P;
      word_count  <= '0;
      err_illegal <= 1'b0;
      overflow    <= 1'b0;
      done        <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_LOAD;
            ptr         <= BASE_P;
            word_count  <= '0;
            err_illegal <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        S_LOAD: begin
          if (full) begin
            if (in_valid) begin
              overflow <= 1'b1;
              done     <= 1'b1;
              state    <= S_FINISH;
            end
          end else if (in_valid) begin
            if (enc_ok) begin
              imem_we    <= 1'b1;
              imem_addr  <= ptr[ADDR_W-1:0];
              imem_wdata <= enc_word;
              ptr        <= ptr + 1'b1;
              word_count <= word_count + 1'b1;
            end else begin
              err_illegal <= 1'b1;
            end
            if (in_last) begin
              done  <= 1'b1;
              state <= S_FINISH;
            end
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Streams symbolic instruction descriptors (kind plus fields) from a testbench or boot host, encodes each into a 32-bit MIPS word, and writes the words into instruction memory at sequential word addresses. This is the writer side of the opcode path that the control unit decodes. It uses the same opcode set: R-format, addi, lw, sw, andi, beq and jal. It sits between the host/boot interface and the IMEM write port, and is active only before the CPU is released from hold.

Parameters:
ADDR_W, 8, IMEM word-address width; capacity is 2**ADDR_W words.
BASE_ADDR, 0, first word address written after start.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising clk
start  in  1  begin a load session (honoured only in IDLE)
in_valid  in  1  descriptor valid
in_ready  out  1  block can accept a descriptor this cycle
in_last  in  1  descriptor is the final one of the session
in_kind  in  3  0 R-fmt, 1 addi, 2 lw, 3 sw, 4 andi, 5 beq, 6 jal, 7 reserved
in_rs  in  5  rs field
in_rt  in  5  rt field
in_rd  in  5  rd field (R-fmt only)
in_shamt  in  5  shamt field (R-fmt only)
in_funct  in  6  funct field (R-fmt only)
in_imm  in  16  immediate / offset (I-fmt)
in_target  in  26  jump target (jal)
imem_we  out  1  IMEM write strobe, one cycle per word
imem_addr  out  ADDR_W  IMEM word address
imem_wdata  out  32  encoded instruction
word_count  out  ADDR_W+1  words written this session
err_illegal  out  1  sticky: an illegal descriptor was dropped
overflow  out  1  sticky: a descriptor was refused because IMEM was full
done  out  1  one-cycle pulse at end of session

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; all outputs 0; the address pointer is loaded with BASE_ADDR. This applies mid-session too: a partial load is abandoned and no further writes occur.
- Handshake: a transfer occurs when in_valid && in_ready. Descriptor fields are only sampled on a transfer.
- FSM states are IDLE, LOAD, FINISH.
  - IDLE: in_ready=0. On start=1 go to LOAD, clear word_count, err_illegal and overflow, and set ptr=BASE_ADDR.
  - LOAD: in_ready=1 unless full. start is ignored.
  - FINISH: done=1 for exactly one cycle, then go to IDLE. word_count and the sticky flags hold until the next start.
- Latency: a descriptor accepted at edge N produces imem_we=1 with its addr/wdata during the cycle after edge N. imem_addr equals ptr at acceptance, then ptr and word_count increment. imem_we=0 at all other times, including in IDLE.
- Encoding:
  - R-fmt: {6'h00, rs, rt, rd, shamt, funct}. Legal funct values are 0x20 add, 0x24 and, 0x27 nor, 0x08 jr, 0x2A slt and 0x00 sll.
  - addi/lw/sw/andi/beq: {op, rs, rt, imm}. Opcodes are 0x08, 0x23, 0x2B, 0x0C and 0x04 respectively.
  - jal: {6'h03, target}.
  - Unused fields are ignored.
- Illegal descriptor: kind 7, or R-fmt with a funct outside the legal list. It is still handshaken (consumed), but there is no write and no ptr or count change. err_illegal is set. If in_last=1 it still ends the session.
- Full: after 2**ADDR_W words have been written, in_ready drops to 0. If in_valid=1 while full, overflow is set and the state goes to FINISH. ptr never wraps.
- in_last on a legal accept: the word is written next cycle, with done in the same cycle as that final imem_we, then the session returns to IDLE. in_ready=0 from the cycle after the in_last accept.
- Simultaneous full and in_last on the same accepted descriptor: the word is written, the session finishes, and overflow stays 0.
- in_valid while in IDLE or FINISH is ignored.

Test Plan:
- Reset, then start, then one R-fmt add (rs=1, rt=2, rd=3, shamt=0, funct=0x20, last) -> next cycle imem_we=1, addr=0, wdata=0x00221820, done=1, word_count=1.
- Back-to-back lw(rs=9, rt=8, imm=4), sw(rs=29, rt=5, imm=8), beq(rs=1, rt=2, imm=0xFFFF), jal(target=0x0100000, last) with in_valid held high -> four consecutive writes to addr 0..3. Data must be 0x8D280004, 0xAFA50008, 0x1022FFFF and 0x0C100000, with no bubbles.
- Illegal: R-fmt with funct=0x3F, then addi(rs=0, rt=4, imm=7, last) -> only one write, addr=0, wdata=0x20040007, err_illegal=1, word_count=1.
- ADDR_W=2: send 5 legal descriptors with no last -> 4 writes at addr 0..3. The fifth is refused (in_ready=0), overflow=1, done pulses, and the state returns to IDLE.
- Assert rst_n=0 after the 2nd accepted word of a 4-word session -> from the next edge, imem_we=0, word_count=0 and the state is IDLE. The remaining descriptors are never accepted.
- start pulsed during LOAD, and in_valid with in_ready=0 in IDLE -> no state change and no write.
